mux8_arbiter: RTL and testbench

Round-robin arbiter that shares one 8:1 bus mux among 8 requesters. It drives the mux's 3-bit select and a one-hot grant vector. A grant is held until the owner drops its request, so the mux path stays stable for multi-cycle transfers. An optional hold-limit stops one requester from monopolising the mux.

---
 rtl/arb_pkg.sv | 15 +
 rtl/rr_pick8.sv | 32 +++
 rtl/mux8_arbiter.sv | 113 +++++++++++
 tb/tb_mux8_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the 8-way bus-mux arbiter.
// Optional hold-limit preemption is enabled by defining ARB_TIMEOUT_EN.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  localparam int unsigned DEF_MAX_HOLD = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick8.sv
// Rotating priority encoder: returns the first eligible requester found
// searching upward from Ptr and wrapping modulo 8. Bits set in Mask are
// excluded from the search.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] Req,
  input  logic [SEL_W-1:0] Ptr,
  input  logic [N_REQ-1:0] Mask,
  output logic             Found,
  output logic [SEL_W-1:0] Idx
);

  logic [N_REQ-1:0] elig;
  logic [SEL_W-1:0] cand;

  // Scan from Ptr upward; the 3-bit add wraps the search order naturally.
  always_comb begin
    elig  = Req & ~Mask;
    Found = 1'b0;
    Idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = Ptr + SEL_W'(i);
      if (!Found && elig[cand]) begin
        Found = 1'b1;
        Idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux8_arbiter.sv
// Round-robin arbiter owning the select of a shared 8:1 bus mux.
// A grant is held until its owner drops Req; on release the next winner
// is granted directly with no idle bubble.
// Define ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD cycles when
// another requester is waiting.
module mux8_arbiter
  import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
)
`endif
(
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [N_REQ-1:0] Req,
  output logic [N_REQ-1:0] Gnt,
  output logic [SEL_W-1:0] S,
  output logic             Valid
);

  state_t           state, state_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [SEL_W-1:0] s_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [N_REQ-1:0] mask;
  logic             found;
  logic [SEL_W-1:0] idx;
  logic             take;
`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt, hold_nxt;
`endif

  rr_pick8 u_pick (
    .Req   (Req),
    .Ptr   (ptr),
    .Mask  (mask),
    .Found (found),
    .Idx   (idx)
  );

  // Next-state: decide whether the picker's winner takes the mux this cycle.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = Gnt;
    s_nxt     = S;
    ptr_nxt   = ptr;
    mask      = '0;
    take      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_nxt  = hold_cnt;
`endif
    unique case (state)
      IDLE: begin
        take = found;
      end
      GRANT: begin
        // The current owner never competes against itself when re-arbitrating.
        mask[S] = 1'b1;
        if (!Req[S]) begin
          take = found;
          if (!found) begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt == HOLD_LAST) begin
          // Saturate here until someone else is waiting.
          take = found;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
`endif
      end
    endcase
    if (take) begin
      state_nxt    = GRANT;
      gnt_nxt      = '0;
      gnt_nxt[idx] = 1'b1;
      s_nxt        = idx;
      ptr_nxt      = idx + SEL_W'(1);
`ifdef ARB_TIMEOUT_EN
      hold_nxt     = '0;
`endif
    end
  end

  // State and output registers; reset drops the grant immediately.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      Gnt      <= '0;
      S        <= '0;
      ptr      <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      state    <= state_nxt;
      Gnt      <= gnt_nxt;
      S        <= s_nxt;
      ptr      <= ptr_nxt;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= hold_nxt;
`endif
    end
  end

  assign Valid = |Gnt;

endmodule

// File: tb/tb_mux8_arbiter.sv
// Scoreboard bench for mux8_arbiter: the driver predicts each cycle's
// outputs from a behavioural model, a monitor compares after every edge.
module tb_mux8_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int MAXH = 4;
`endif

  logic       Clock = 1'b0;
  logic       Reset_n;
  logic [7:0] Req;
  logic [7:0] Gnt;
  logic [2:0] S;
  logic       Valid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] s;
    logic       v;
  } exp_t;

  exp_t q[$];

  // Model state: current owner (-1 when none), pointer, hold count, last select.
  int m_owner, m_ptr, m_hold, m_s;

`ifdef ARB_TIMEOUT_EN
  mux8_arbiter #(.MAX_HOLD(MAXH)) dut (
`else
  mux8_arbiter dut (
`endif
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Req     (Req),
    .Gnt     (Gnt),
    .S       (S),
    .Valid   (Valid)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [7:0] r, input int from, input int skip);
    for (int k = 0; k < 8; k++) begin
      int c;
      c = (from + k) % 8;
      if (c != skip && r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_s     = 0;
  endtask

  task automatic give(input int w);
    m_owner = w;
    m_s     = w;
    m_ptr   = (w + 1) % 8;
    m_hold  = 0;
  endtask

  // Apply one cycle's request vector to the model and queue the expected result.
  task automatic model_step(input logic [7:0] r);
    int w;
    exp_t e;
    if (m_owner < 0) begin
      w = pick(r, m_ptr, -1);
      if (w >= 0) give(w);
    end else if (!r[m_owner]) begin
      w = pick(r, m_ptr, m_owner);
      if (w >= 0) give(w);
      else m_owner = -1;
    end
`ifdef ARB_TIMEOUT_EN
    else if (m_hold == MAXH - 1) begin
      w = pick(r, m_ptr, m_owner);
      if (w >= 0) give(w);
    end else begin
      m_hold++;
    end
`endif
    e.gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    e.s   = 3'(m_s);
    e.v   = (m_owner >= 0);
    q.push_back(e);
  endtask

  task automatic cyc(input logic [7:0] r);
    @(negedge Clock);
    Req = r;
    model_step(r);
  endtask

  // Monitor: compare whatever the DUT presents after each rising edge.
  always @(posedge Clock) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("gnt",   32'(Gnt),   32'(e.gnt));
      chk("sel",   32'(S),     32'(e.s));
      chk("valid", 32'(Valid), 32'(e.v));
      chk("onehot", 32'($countones(Gnt) <= 1), 32'(1));
    end
  end

  initial begin
    logic [7:0] r;
    model_reset();
    // Reset held with every request asserted.
    Reset_n = 1'b0;
    Req     = 8'hFF;
    repeat (2) @(negedge Clock);
    chk("rst_gnt",   32'(Gnt),   32'h0);
    chk("rst_sel",   32'(S),     32'h0);
    chk("rst_valid", 32'(Valid), 32'h0);
    Req     = 8'h00;
    Reset_n = 1'b1;
    cyc(8'h00);

    // Single requester grant and release; S keeps its last value.
    repeat (5) cyc(8'h04);
    repeat (2) cyc(8'h00);

    // Asynchronous reset in the middle of a grant.
    repeat (2) cyc(8'h10);
    @(posedge Clock);
    #3;
    Reset_n = 1'b0;
    #1;
    chk("async_rst_gnt",   32'(Gnt),   32'h0);
    chk("async_rst_valid", 32'(Valid), 32'h0);
    Req = 8'h00;
    @(negedge Clock);
    Reset_n = 1'b1;
    model_reset();

    // Wrap-around: 0 -> 7 -> 0.
    repeat (2) cyc(8'h81);
    repeat (2) cyc(8'h80);
    repeat (2) cyc(8'h01);
    cyc(8'h00);

    // Handover in the same cycle as release, no bubble.
    repeat (2) cyc(8'h08);
    repeat (2) cyc(8'h20);
    cyc(8'h00);

    // Two steady requesters (alternates only with the hold limit).
    repeat (20) cyc(8'h03);
    cyc(8'h00);

    // Lone requester held long: never preempted.
    repeat (20) cyc(8'h01);
    cyc(8'h00);

    // Random traffic: each bit flips with probability 1/4 per cycle.
    r = 8'h00;
    for (int i = 0; i < 400; i++) begin
      r = r ^ 8'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) r = 8'h00;
      cyc(r);
    end

    repeat (3) @(negedge Clock);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
